// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

    localparam int unsigned DIGIT_W        = 4;
    localparam int unsigned BCD_DIGITS     = 4;
    localparam int unsigned SCRATCH_DIGITS = BCD_DIGITS + 1;
    localparam int unsigned BCD_W          = BCD_DIGITS * DIGIT_W;
    localparam int unsigned SCRATCH_W      = SCRATCH_DIGITS * DIGIT_W;

    localparam logic [BCD_W-1:0] BCD_SAT = 16'h9999;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

endpackage : bin2bcd_seq_pkg

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
module bcd_add3
    import bin2bcd_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adj_c
);

    assign adj_c = (digit >= DIGIT_W'(5)) ? digit + DIGIT_W'(3) : digit;

endmodule : bcd_add3

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle,
// saturating to 9999 with an overflow flag.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int unsigned BIN_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [BIN_W-1:0]   bin_in,
    output logic               busy,
    output logic               done,
    output logic               ovf,
    output logic [BCD_W-1:0]   bcd_out
);

    localparam int unsigned      CNT_W     = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    state_e                 state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [BIN_W-1:0]       bin_q, bin_d;
    logic [SCRATCH_W-1:0]   scratch, scratch_d, scratch_adj;
    logic                   busy_d, done_d, ovf_d;
    logic [BCD_W-1:0]       bcd_d;

    // One correction cell per scratch digit, applied before each shift
    for (genvar g = 0; g < SCRATCH_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit (scratch[g*DIGIT_W +: DIGIT_W]),
            .adj_c (scratch_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bin_d     = bin_q;
        scratch_d = scratch;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        ovf_d     = ovf;
        bcd_d     = bcd_out;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    bin_d     = bin_in;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = ST_CONV;
                end
            end
            ST_CONV: begin
                // The binary MSB falls into the scratch LSB; the scratch MSB drops out
                {scratch_d, bin_d} = {scratch_adj, bin_q} << 1;
                cnt_d  = cnt + CNT_W'(1);
                busy_d = 1'b1;
                if (cnt == LAST_ITER) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (scratch[SCRATCH_W-1 -: DIGIT_W] != '0) begin
                    bcd_d = BCD_SAT;
                    ovf_d = 1'b1;
                end else begin
                    bcd_d = scratch[BCD_W-1:0];
                    ovf_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bin_q   <= '0;
            scratch <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            bcd_out <= '0;
        end else begin
            cnt     <= cnt_d;
            bin_q   <= bin_d;
            scratch <= scratch_d;
            busy    <= busy_d;
            done    <= done_d;
            ovf     <= ovf_d;
            bcd_out <= bcd_d;
        end
    end

endmodule : bin2bcd_seq

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed vectors, corner sequences and
// a long back-to-back random run against an arithmetic reference model.
module tb_bin2bcd_seq;

    localparam int unsigned BIN_W  = 16;
    localparam int unsigned PERIOD = BIN_W + 2;
    localparam int unsigned LAT    = BIN_W + 1;
    localparam int unsigned N_RAND = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bin_in = '0;
    logic        busy, done, ovf;
    logic [15:0] bcd_out;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0] val;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t tbl[12];

    bin2bcd_seq #(.BIN_W(BIN_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf),
        .bcd_out (bcd_out)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] ref_model(input int unsigned v);
        if (v > 9999) return {1'b1, 16'h9999};
        return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_digits(input string name);
        logic [15:0] b;
        logic        bad;
        b   = bcd_out;
        bad = 1'b0;
        for (int d = 0; d < 4; d++) begin
            if (b[d*4 +: 4] > 4'd9) bad = 1'b1;
        end
        check(name, 32'(bad), 32'd0);
    endtask

    // Launch one conversion and verify latency, busy width, result and hold.
    task automatic convert(input string name, input logic [15:0] v,
                           input logic [15:0] exp_bcd, input logic exp_ovf,
                           input bit release_rst);
        int lat;
        int busy_cnt;
        logic [15:0] got;
        @(negedge clk);
        if (release_rst) rst_n = 1'b1;
        start  = 1'b1;
        bin_in = v;
        @(posedge clk);
        #1;
        start    = 1'b0;
        busy_cnt = busy ? 1 : 0;
        lat      = 0;
        for (int c = 1; c <= 40; c++) begin
            bin_in = 16'($urandom);
            @(posedge clk);
            #1;
            lat = c;
            if (done) break;
            if (busy) busy_cnt++;
        end
        check({name, " latency"}, 32'(lat), 32'(LAT));
        check({name, " busy_cycles"}, 32'(busy_cnt), 32'(BIN_W));
        check({name, " busy_at_done"}, 32'(busy), 32'd0);
        check({name, " bcd"}, 32'(bcd_out), 32'(exp_bcd));
        check({name, " ovf"}, 32'(ovf), 32'(exp_ovf));
        check_digits({name, " digits"});
        got = bcd_out;
        @(posedge clk);
        #1;
        check({name, " done_one_cycle"}, 32'(done), 32'd0);
        check({name, " hold"}, 32'(bcd_out), 32'(got));
    endtask

    initial begin
        int ndone;
        logic [15:0] last_bcd;
        logic [16:0] r;
        logic [15:0] q[$];
        int unsigned pick;

        tbl[0]  = '{16'd1234,  16'h1234, 1'b0};
        tbl[1]  = '{16'd0,     16'h0000, 1'b0};
        tbl[2]  = '{16'd9999,  16'h9999, 1'b0};
        tbl[3]  = '{16'd10000, 16'h9999, 1'b1};
        tbl[4]  = '{16'd65535, 16'h9999, 1'b1};
        tbl[5]  = '{16'd42,    16'h0042, 1'b0};
        tbl[6]  = '{16'd1,     16'h0001, 1'b0};
        tbl[7]  = '{16'd9,     16'h0009, 1'b0};
        tbl[8]  = '{16'd10,    16'h0010, 1'b0};
        tbl[9]  = '{16'd99,    16'h0099, 1'b0};
        tbl[10] = '{16'd100,   16'h0100, 1'b0};
        tbl[11] = '{16'd5000,  16'h5000, 1'b0};

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("reset bcd", 32'(bcd_out), 32'h0);
        check("reset ovf", 32'(ovf), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            convert($sformatf("vec%0d", i), tbl[i].val, tbl[i].bcd, tbl[i].ovf, 1'b0);
        end

        // Start pulses mid-conversion and during the done edge are ignored
        @(negedge clk);
        start  = 1'b1;
        bin_in = 16'd300;
        @(posedge clk);
        #1;
        ndone    = 0;
        last_bcd = '0;
        for (int c = 1; c <= 45; c++) begin
            start  = (c == 4 || c == 5 || c == 16);
            bin_in = (c < 20) ? 16'd9999 : 16'($urandom);
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                last_bcd = bcd_out;
            end
        end
        start = 1'b0;
        check("ignore_start done_count", 32'(ndone), 32'd1);
        check("ignore_start bcd", 32'(last_bcd), 32'h0300);
        check("ignore_start ovf", 32'(ovf), 32'd0);

        // Reset at iteration 8 aborts the conversion
        @(negedge clk);
        start  = 1'b1;
        bin_in = 16'd1234;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort bcd", 32'(bcd_out), 32'h0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        check("abort no_done", 32'(ndone), 32'd0);

        // Start accepted on the very first edge after reset release
        rst_n = 1'b0;
        #2;
        convert("post_reset7", 16'd7, 16'h0007, 1'b0, 1'b1);

        // Start held high: one result every PERIOD cycles
        @(negedge clk);
        start = 1'b1;
        for (int j = 0; j < int'(N_RAND * PERIOD); j++) begin
            pick = $urandom_range(0, 7);
            case (pick)
                0: bin_in = 16'd0;
                1: bin_in = 16'd9999;
                2: bin_in = 16'd10000;
                3: bin_in = 16'd65535;
                default: bin_in = 16'($urandom_range(0, 65535));
            endcase
            if (j % PERIOD == 0) q.push_back(bin_in);
            @(posedge clk);
            #1;
            check("stream done", 32'(done), 32'((j % PERIOD) == PERIOD - 1));
            check("stream busy", 32'(busy),
                  32'((j % PERIOD) >= 1 && (j % PERIOD) <= BIN_W));
            if ((j % PERIOD) == PERIOD - 1) begin
                if (q.size() == 0) begin
                    check("stream queue_empty", 32'd1, 32'd0);
                end else begin
                    r = ref_model(int'(q.pop_front()));
                    check("stream bcd", 32'(bcd_out), 32'(r[15:0]));
                    check("stream ovf", 32'(ovf), 32'(r[16]));
                end
            end
            check_digits("stream digits");
        end
        start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_bin2bcd_seq
